// File: rtl/controlador_fetch_if.sv
// controlador_fetch_if: instruction-memory, hazard-unit and IF/ID signals of the fetch controller
interface controlador_fetch_if;
    logic [9:0]  direccion;
    logic [31:0] instruccion;
    logic        stall;
    logic        salto;
    logic [9:0]  destino;
    logic        arranque;
    logic [31:0] instr_id;
    logic [9:0]  pc_id;
    logic        valido_id;
    logic        detenido;

    modport master (
        output direccion, instr_id, pc_id, valido_id, detenido,
        input  instruccion, stall, salto, destino, arranque
    );

    modport slave (
        input  direccion, instr_id, pc_id, valido_id, detenido,
        output instruccion, stall, salto, destino, arranque
    );
endinterface

// File: rtl/controlador_fetch.sv
// controlador_fetch: instruction fetch controller with replay on stall, redirect and halt/restart
module controlador_fetch #(
    parameter logic [9:0]  DIR_INICIO = 10'd0,
    parameter logic [31:0] COD_HLT    = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    controlador_fetch_if.master   bus
);
    typedef enum logic {FETCH, DETENIDO} estado_t;

    estado_t    estado;
    logic [9:0] pc;
    logic [9:0] pc_vuelo;
    logic       valido_vuelo;
    logic       hlt;

    assign hlt = valido_vuelo && (bus.instruccion == COD_HLT);

    // Memory address: redirect target, replay of the in-flight word while stalled, else next pc
    always_comb
        bus.direccion = !reset_n ? DIR_INICIO :
                        bus.salto ? bus.destino :
                        (estado == FETCH && bus.stall) ? pc_vuelo : pc;

    // Fetch state machine with registered IF/ID outputs; salto overrides everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc            <= DIR_INICIO;
            pc_vuelo      <= DIR_INICIO;
            valido_vuelo  <= 1'b0;
            estado        <= FETCH;
            bus.instr_id  <= '0;
            bus.pc_id     <= '0;
            bus.valido_id <= 1'b0;
            bus.detenido  <= 1'b0;
        end else if (bus.salto) begin
            pc            <= bus.destino + 10'd1;
            pc_vuelo      <= bus.destino;
            valido_vuelo  <= 1'b1;
            estado        <= FETCH;
            bus.valido_id <= 1'b0;
            bus.detenido  <= 1'b0;
        end else if (estado == DETENIDO) begin
            bus.valido_id <= 1'b0;
            if (bus.arranque) begin
                pc           <= DIR_INICIO;
                valido_vuelo <= 1'b0;
                estado       <= FETCH;
                bus.detenido <= 1'b0;
            end
        end else if (!bus.stall) begin
            pc            <= pc + 10'd1;
            pc_vuelo      <= pc;
            valido_vuelo  <= !hlt;
            estado        <= hlt ? DETENIDO : FETCH;
            bus.instr_id  <= bus.instruccion;
            bus.pc_id     <= pc_vuelo;
            bus.valido_id <= valido_vuelo;
            bus.detenido  <= hlt;
        end
    end
endmodule

// File: tb/tb_controlador_fetch.sv
// tb_controlador_fetch: directed-vector bench for the fetch controller with a registered ROM model
module tb_controlador_fetch;
    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] rom [1024];
    logic [31:0] mem_q = '0;

    controlador_fetch_if bus ();

    controlador_fetch #(.DIR_INICIO(10'd0), .COD_HLT(32'h00000000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: registers rom[direccion] each rising edge
    always @(posedge clk) mem_q <= rom[bus.direccion];
    assign bus.instruccion = mem_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_id(input string tag, input logic [9:0] pc, input logic [31:0] instr);
        chk({tag, ".valido"}, {31'd0, bus.valido_id}, 32'd1);
        chk({tag, ".pc"}, {22'd0, bus.pc_id}, {22'd0, pc});
        chk({tag, ".instr"}, bus.instr_id, instr);
    endtask

    task automatic expect_idle(input string tag, input logic det);
        chk({tag, ".valido"}, {31'd0, bus.valido_id}, 32'd0);
        chk({tag, ".detenido"}, {31'd0, bus.detenido}, {31'd0, det});
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, ".dir"}, {22'd0, bus.direccion}, 32'd0);
        chk({tag, ".instr"}, bus.instr_id, 32'd0);
        chk({tag, ".pc"}, {22'd0, bus.pc_id}, 32'd0);
        expect_idle(tag, 1'b0);
    endtask

    // Called in cycle 0 (just released); ends in cycle 6 with the controller halted
    task automatic straight(input string tag);
        chk({tag, ".c0dir"}, {22'd0, bus.direccion}, 32'd0);
        step();
        step();
        expect_id({tag, ".c2"}, 10'd0, 32'h20420020);
        step();
        expect_id({tag, ".c3"}, 10'd1, 32'h20630001);
        step();
        expect_id({tag, ".c4"}, 10'd2, 32'h00432006);
        step();
        expect_id({tag, ".c5"}, 10'd3, 32'h00000000);
        step();
        expect_idle({tag, ".c6"}, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
        rom[0]    = 32'h20420020;
        rom[1]    = 32'h20630001;
        rom[2]    = 32'h00432006;
        rom[1023] = 32'h20420020;
        reset_n     = 1'b0;
        bus.stall    = 1'b0;
        bus.salto    = 1'b0;
        bus.destino  = 10'd0;
        bus.arranque = 1'b0;
        #1;
        expect_reset("rst0");
        step();
        step();
        reset_n = 1'b1;
        straight("s1");

        bus.stall = 1'b1;
        step();
        expect_idle("halt_stall1", 1'b1);
        step();
        expect_idle("halt_stall2", 1'b1);
        bus.stall    = 1'b0;
        bus.arranque = 1'b1;
        step();
        bus.arranque = 1'b0;
        expect_idle("arr_p1", 1'b0);
        step();
        expect_idle("arr_p2", 1'b0);
        step();
        expect_id("arr_p3", 10'd0, 32'h20420020);
        step();
        expect_id("arr_p4", 10'd1, 32'h20630001);

        bus.stall = 1'b1;
        #1;
        chk("stall.dir", {22'd0, bus.direccion}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_id("stall.hold", 10'd1, 32'h20630001);
        end
        bus.stall = 1'b0;
        step();
        expect_id("stall.rel", 10'd2, 32'h00432006);
        step();
        expect_id("stall.hlt", 10'd3, 32'h00000000);
        step();
        expect_idle("stall.halted", 1'b1);

        bus.arranque = 1'b1;
        step();
        bus.arranque = 1'b0;
        step();
        step();
        expect_id("rd.pc0", 10'd0, 32'h20420020);
        step();
        expect_id("rd.pc1", 10'd1, 32'h20630001);
        bus.salto   = 1'b1;
        bus.destino = 10'd0;
        bus.stall   = 1'b1;
        #1;
        chk("rd.dir", {22'd0, bus.direccion}, 32'd0);
        step();
        bus.salto = 1'b0;
        bus.stall = 1'b0;
        expect_idle("rd.bubble", 1'b0);
        step();
        expect_id("rd.target", 10'd0, 32'h20420020);

        bus.salto   = 1'b1;
        bus.destino = 10'd1023;
        #1;
        chk("wrap.dir", {22'd0, bus.direccion}, 32'd1023);
        step();
        bus.salto = 1'b0;
        expect_idle("wrap.bubble", 1'b0);
        step();
        expect_id("wrap.1023", 10'd1023, 32'h20420020);
        step();
        expect_id("wrap.0", 10'd0, 32'h20420020);
        step();
        expect_id("wrap.1", 10'd1, 32'h20630001);
        step();
        step();
        expect_id("wrap.hlt", 10'd3, 32'h00000000);
        step();
        expect_idle("wrap.halted", 1'b1);

        bus.salto    = 1'b1;
        bus.destino  = 10'd1;
        bus.arranque = 1'b1;
        step();
        bus.salto    = 1'b0;
        bus.arranque = 1'b0;
        expect_idle("hsalto.bubble", 1'b0);
        step();
        expect_id("hsalto.pc1", 10'd1, 32'h20630001);
        bus.arranque = 1'b1;
        step();
        bus.arranque = 1'b0;
        expect_id("arr_fetch", 10'd2, 32'h00432006);

        bus.stall = 1'b1;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        expect_reset("rst_mid");
        bus.stall = 1'b0;
        step();
        reset_n = 1'b1;
        straight("s2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/controlador_fetch.md
CONTROLADOR_FETCH -- requirements
Module: controlador_fetch

Interface
REQ-001 SHALL have parameter DIR_INICIO, default 10'd0: fetch address after reset and after arranque.
REQ-002 SHALL have parameter COD_HLT, default 32'h00000000: instruction word decoded as halt.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock, shared with the instruction memory.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 direccion  out  10  address to the instruction memory; memory registers rom[direccion] at each rising edge.
REQ-007 instruccion  in  32  memory read data, valid the cycle after direccion is sampled.
REQ-008 stall  in  1  hazard-unit hold request.
REQ-009 salto  in  1  redirect request (jump or taken branch).
REQ-010 destino  in  10  redirect target, qualified by salto.
REQ-011 arranque  in  1  single-cycle restart pulse while halted.
REQ-012 instr_id  out  32  registered IF/ID instruction.
REQ-013 pc_id  out  10  registered address of instr_id.
REQ-014 valido_id  out  1  instr_id/pc_id hold a valid instruction this cycle.
REQ-015 detenido  out  1  controller halted.

Function
REQ-016 SHALL keep the registers pc (next address), pc_vuelo (address in flight in memory), valido_vuelo, and estado in {FETCH, DETENIDO}.
REQ-017 Latency SHALL be exactly 2 cycles from direccion=A to valido_id=1 with pc_id=A, absent stall/salto.
REQ-018 In FETCH with no stall or salto, direccion SHALL equal pc; at the edge: pc<=pc+1, pc_vuelo<=pc, valido_vuelo<=1, and the IF/ID outputs load instruccion, pc_vuelo and valido_vuelo.
REQ-019 pc arithmetic SHALL be modulo 1024: 1023+1 = 0, with no flag.
REQ-020 stall=1 (no salto) SHALL hold pc, pc_vuelo, valido_vuelo and the IF/ID outputs, and SHALL drive direccion=pc_vuelo (replay) so that the in-flight word is still present on instruccion when stall drops.
REQ-021 salto=1 SHALL take priority over stall, HLT detection and estado.
REQ-022 On salto=1: direccion=destino combinationally in the same cycle; at the edge pc<=destino+1, pc_vuelo<=destino, valido_vuelo<=1, valido_id<=0; the current instruccion is discarded.
REQ-023 When valido_vuelo=1 and instruccion==COD_HLT in FETCH without stall/salto, the HLT word SHALL be loaded into IF/ID with valido_id=1, and estado<=DETENIDO, valido_vuelo<=0.
REQ-024 In DETENIDO: detenido=1, valido_id=0 from the next edge, pc/pc_vuelo held, direccion=pc, and stall ignored.
REQ-025 In DETENIDO, arranque=1 SHALL restart: pc<=DIR_INICIO, valido_vuelo<=0, estado<=FETCH, with the first valid instruction 3 cycles after the pulse.
REQ-026 In DETENIDO, salto=1 SHALL resume per REQ-022 and set estado<=FETCH; salto wins over a simultaneous arranque.
REQ-027 arranque in FETCH SHALL be ignored.
REQ-028 detenido SHALL be a registered decode of estado==DETENIDO.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for clk, force pc=DIR_INICIO, pc_vuelo=DIR_INICIO, valido_vuelo=0, estado=FETCH, instr_id=0, pc_id=0, valido_id=0, detenido=0; direccion=DIR_INICIO while held.
REQ-030 Reset mid-operation SHALL drop any in-flight or halted state; after release, fetching restarts per REQ-017 from DIR_INICIO.

Verification
Memory: rom[0]=20420020, rom[1]=20630001, rom[2]=00432006, all others 0 unless stated; cycle 0 = first edge after reset release.
REQ-031 Straight-line case: valido_id=1 in cycles 2/3/4 with pc_id 0/1/2 and instr_id 20420020/20630001/00432006; cycle 5 pc_id=3 instr 0; cycle 6 detenido=1, valido_id=0.
REQ-032 Stall case: stall=1 for 3 cycles while pc_id=1 -> instr_id holds 20630001; after release the next pc_id=2 (00432006), with no gap and no duplicate.
REQ-033 Redirect case: salto=1 with destino=0 and stall=1 in the cycle pc_id=1 -> valido_id=0 next cycle; direccion=0 that cycle; pc_id=0 valid 2 cycles after salto.
REQ-034 Halt/restart case: halted per REQ-031, then arranque pulse -> detenido=0 next cycle; pc_id=0 valid 3 cycles after the pulse; stall while halted has no effect.
REQ-035 Wrap case: bench memory with rom[1023]=20420020; salto destino=1023 -> pc_id 1023, then pc_id 0 (20420020) on consecutive valid cycles.
REQ-036 Async reset case: reset_n pulsed low mid-cycle during REQ-032 -> all outputs take their REQ-029 values before the next edge; REQ-031 sequence repeats after release.
